// File: rtl/aes_lfsr_stim_engine.sv
// Stimulus/capture engine for pipelined block-cipher cores.
// Two Galois LFSRs supply plaintext and key, one vector per cycle.
// A LATENCY-deep valid pipe tags the results coming back, and each
// captured result is folded into a rotate-XOR signature.
module aes_lfsr_stim_engine #(
    parameter int unsigned W       = 128,
    parameter int unsigned LATENCY = 21,
    parameter logic [W-1:0] TAPS   = {1'b1, {(W-8){1'b0}}, 7'h43},
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tests,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic [W-1:0]     seed_state,
    input  logic [W-1:0]     seed_key,
    output logic [W-1:0]     dut_state,
    output logic [W-1:0]     dut_key,
    output logic             issue_valid,
    input  logic [W-1:0]     dut_out,
    output logic             cap_valid,
    output logic [CNT_W-1:0] cap_index,
    output logic [W-1:0]     signature,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] captured_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       lfsr_state;
    logic [W-1:0]       lfsr_key;
    logic [CNT_W-1:0]   num_q;
    logic [1:0]         mode_q;
    logic [LATENCY-1:0] vpipe;
    logic               accept_c;
    logic               issue_c;

    // One Galois step: shift right, fold the feedback mask in when bit 0 falls out.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] q);
        return (q >> 1) ^ ({W{q[0]}} & TAPS);
    endfunction

    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    function automatic logic [W-1:0] seed_fix(input logic [W-1:0] s);
        return (s == '0) ? W'(1) : s;
    endfunction

    // Vector presentation is combinational in pause so a held cycle issues nothing.
    assign issue_valid = issue_c;
    assign dut_state   = lfsr_state;
    assign dut_key     = lfsr_key;
    assign cap_valid   = vpipe[LATENCY-1];
    assign cap_index   = captured_cnt;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        issue_c   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = (num_tests == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    issue_c = 1'b1;
                    if (issued_cnt == num_q - CNT_W'(1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cap_valid && (captured_cnt == num_q - CNT_W'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: LFSRs, counters, valid pipe, signature and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_state   <= '0;
            lfsr_key     <= '0;
            num_q        <= '0;
            mode_q       <= '0;
            vpipe        <= '0;
            issued_cnt   <= '0;
            captured_cnt <= '0;
            signature    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done <= (state_nxt == S_DONE);
            if (accept_c) begin
                lfsr_state   <= seed_fix(seed_state);
                lfsr_key     <= seed_fix(seed_key);
                num_q        <= num_tests;
                mode_q       <= mode;
                vpipe        <= '0;
                issued_cnt   <= '0;
                captured_cnt <= '0;
                signature    <= '0;
            end else begin
                // Pipe shifts every cycle so paused issue never stalls returning results.
                vpipe <= LATENCY'({vpipe, issue_c});
                if (issue_c) begin
                    issued_cnt <= issued_cnt + CNT_W'(1);
                    if (!mode_q[1]) begin
                        lfsr_state <= lfsr_step(lfsr_state);
                    end
                    if (!mode_q[0]) begin
                        lfsr_key <= lfsr_step(lfsr_key);
                    end
                end
                if (cap_valid) begin
                    captured_cnt <= captured_cnt + CNT_W'(1);
                    signature    <= {signature[W-2:0], signature[W-1]} ^ dut_out;
                end
            end
        end
    end

endmodule
